// File: rtl/if_fetch_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_buf_pkg
// Brief    : Shared CPU defines for the instruction-fetch buffer.
// Revision : 1.0
// ============================================================================
package if_fetch_buf_pkg;

    localparam int InstAddrBus = 6;
    localparam int InstBus     = 32;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b0;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage : if_fetch_buf_pkg
`default_nettype wire

// File: rtl/if_fetch_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Parameterised synchronous FIFO with occupancy count and clear.
// Revision : 1.0
// ============================================================================
module sync_fifo
    import if_fetch_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read port is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (rst != RstEnable && !clr && do_push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin : p_no_overflow
        if (rst != RstEnable && !clr && push)
            assert (!full);
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_buf
// Brief    : Fetch stage: issues ROM reads from the PC stream and buffers
//            PC-tagged instructions for decode behind a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int AW    = InstAddrBus,
    parameter int DW    = InstBus,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          ce,
    output logic          pc_stall,
    output logic          rom_ce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          flush,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [DW-1:0] id_inst,
    output logic [AW-1:0] id_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic             empty;
    logic             inflight;
    logic [AW-1:0]    inflight_pc;
    logic             space;
    logic             pop;
    logic [AW+DW-1:0] head;

    // The in-flight read already owns a slot; a same-cycle pop earns no credit.
    assign space    = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
    assign rom_ce   = ce & space & ~flush;
    assign rom_addr = pc;
    assign pc_stall = ce & (~space | flush);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            inflight    <= ChipDisable;
            inflight_pc <= '0;
        end else begin
            inflight    <= rom_ce;
            inflight_pc <= rom_addr;
        end
    end

    assign id_valid = ~empty;
    assign pop      = id_valid & id_ready;
    assign id_inst  = head[DW-1:0];
    assign id_pc    = head[AW+DW-1:DW];

    sync_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (inflight),
        .pop   (pop),
        .wdata ({inflight_pc, rom_data}),
        .rdata (head),
        .count (count),
        .empty (empty)
    );

endmodule : if_fetch_buf
`default_nettype wire

// File: tb/tb_if_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_buf
// Brief    : Directed self-checking bench for if_fetch_buf with PC and ROM models.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_buf;
    import if_fetch_buf_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          ce;
    logic          pc_stall;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] id_inst;
    logic [AW-1:0] id_pc;

    int            checks   = 0;
    int            failures = 0;
    logic [AW-1:0] exp_pc;

    always #5 clk = ~clk;

    if_fetch_buf #(.AW(AW), .DW(DW), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .ce       (ce),
        .pc_stall (pc_stall),
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_inst  (id_inst),
        .id_pc    (id_pc)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    // One cycle: score any handshake at negedge, then model PC source and ROM.
    task automatic tick();
        logic          adv;
        logic          rd;
        logic [AW-1:0] ra;
        @(negedge clk);
        if (id_valid && id_ready) begin
            check("id_pc", 64'(id_pc), 64'(exp_pc));
            check("id_inst", 64'(id_inst), 64'(rom_word(exp_pc)));
            exp_pc = exp_pc + 1'b1;
        end
        if (pc_stall) check("rom_ce_when_stall", 64'(rom_ce), 64'd0);
        adv = ce && !pc_stall;
        rd  = rom_ce;
        ra  = rom_addr;
        @(posedge clk);
        #1;
        if (adv) pc = pc + 1'b1;
        if (rd)  rom_data = rom_word(ra);
    endtask

    task automatic do_reset();
        rst = 1'b0; ce = 1'b0; flush = 1'b0; id_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1; pc = '0; exp_pc = '0;
    endtask

    initial begin
        rst = 1'b0; pc = '0; ce = 1'b0; flush = 1'b0; id_ready = 1'b0;
        rom_data = '0; exp_pc = '0;

        // Reset then steady stream
        do_reset();
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_inst", 64'(id_inst), 64'd0);
        check("rst_id_pc", 64'(id_pc), 64'd0);
        check("rst_rom_ce", 64'(rom_ce), 64'd0);
        check("rst_pc_stall", 64'(pc_stall), 64'd0);
        ce = 1'b1; id_ready = 1'b1;
        #1 check("issue_rom_ce", 64'(rom_ce), 64'd1);
        check("issue_rom_addr", 64'(rom_addr), 64'd0);
        tick();
        check("lat_n1_valid", 64'(id_valid), 64'd0);
        tick();
        check("lat_n2_valid", 64'(id_valid), 64'd1);
        check("lat_n2_pc", 64'(id_pc), 64'd0);
        check("lat_n2_inst", 64'(id_inst), 64'(32'hA000_0000));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stream_valid", 64'(id_valid), 64'd1);
            check("stream_no_stall", 64'(pc_stall), 64'd0);
        end
        check("stream_count", 64'(exp_pc), 64'd10);

        // Back-pressure
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("bp_stall", 64'(pc_stall), 64'd1);
        check("bp_rom_ce", 64'(rom_ce), 64'd0);
        check("bp_pc_held", 64'(pc), 64'd4);
        check("bp_head_pc", 64'(id_pc), 64'd0);
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("bp_drain_valid", 64'(id_valid), 64'd1);
        end
        check("bp_drain_count", 64'(exp_pc), 64'd12);

        // Toggling ready with a full FIFO
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 30; i++) begin
            id_ready = i[0];
            tick();
        end
        ce = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("tog_drained", 64'(id_valid), 64'd0);
        check("tog_all_delivered", 64'(exp_pc), 64'(pc));

        // Flush with an in-flight read and two buffered entries
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        #1 check("fl_rom_ce", 64'(rom_ce), 64'd0);
        check("fl_pc_stall", 64'(pc_stall), 64'd1);
        check("fl_pre_valid", 64'(id_valid), 64'd1);
        tick();
        flush = 1'b0; pc = 6'h20; exp_pc = 6'h20; id_ready = 1'b1;
        check("fl_post_valid", 64'(id_valid), 64'd0);
        tick();
        check("fl_no_stray", 64'(id_valid), 64'd0);
        tick();
        check("fl_resume_valid", 64'(id_valid), 64'd1);
        check("fl_resume_pc", 64'(id_pc), 64'h20);
        check("fl_resume_inst", 64'(id_inst), 64'(32'hA000_0020));
        for (int i = 0; i < 4; i++) tick();
        check("fl_resume_count", 64'(exp_pc), 64'h24);

        // Reset mid-operation
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; ce = 1'b0; id_ready = 1'b1;
        check("mrst_valid", 64'(id_valid), 64'd0);
        check("mrst_inst", 64'(id_inst), 64'd0);
        check("mrst_pc", 64'(id_pc), 64'd0);
        check("mrst_stall", 64'(pc_stall), 64'd0);
        tick();
        tick();
        check("mrst_rom_ignored", 64'(id_valid), 64'd0);

        // ce gaps: 1,0,0,1
        do_reset();
        id_ready = 1'b1;
        ce = 1'b1;
        #1 check("gap_rom_ce0", 64'(rom_ce), 64'd1);
        tick();
        ce = 1'b0;
        #1 check("gap_rom_ce1", 64'(rom_ce), 64'd0);
        tick();
        tick();
        ce = 1'b1;
        #1 check("gap_rom_ce3", 64'(rom_ce), 64'd1);
        check("gap_rom_addr3", 64'(rom_addr), 64'd1);
        tick();
        ce = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("gap_delivered", 64'(exp_pc), 64'd2);
        check("gap_empty", 64'(id_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch_buf
`default_nettype wire

// File: doc/if_fetch_buf.md
Name: if_fetch_buf

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the PC/ce stream and issues reads to the synchronous instruction ROM (1-cycle read latency).
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them to decode with a valid/ready handshake.
- Back-pressures the PC source with a stall output and supports a pipeline flush.

Parameters:
- AW, 6, instruction address / PC width.
- DW, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; rst==0 at a rising clk edge resets the block.
- pc  input  AW  fetch address from the PC register.
- ce  input  1  PC valid / fetch enable from the PC register.
- pc_stall  output  1  PC source must hold pc this cycle.
- rom_ce  output  1  ROM read enable.
- rom_addr  output  AW  ROM read address.
- rom_data  input  DW  ROM read data, valid the cycle after rom_ce.
- flush  input  1  discard all buffered and in-flight fetches.
- id_valid  output  1  id_inst/id_pc hold a valid instruction.
- id_ready  input  1  decode accepts the head entry.
- id_inst  output  DW  head instruction.
- id_pc  output  AW  PC of head instruction.

Behaviour:
- Reset (rst==0 at edge): FIFO empty (count=0, rd_ptr=wr_ptr=0), inflight=0.
  - Reset values: id_valid=0, id_inst=0, id_pc=0, rom_ce=0, pc_stall=0 (while ce=0).
  - Reset mid-operation drops all contents and any in-flight read; the ROM response the following cycle is ignored.
- Issue (combinational):
  - space = (count + inflight < DEPTH). Conservative: no credit is taken for a same-cycle pop.
  - rom_ce = ce & space & ~flush; rom_addr = pc (pass-through).
  - pc_stall = ce & (~space | flush).
  - The PC source must hold pc while pc_stall=1, so no address is skipped.
- In-flight tracking:
  - At the edge, inflight <= rom_ce and inflight_pc <= rom_addr.
- Capture:
  - In the cycle inflight==1, rom_data and inflight_pc are written to FIFO[wr_ptr] at the edge, unless flush or reset is active.
  - The space check guarantees the FIFO is never full at capture; an assertion covers this.
- Output:
  - id_valid = (count != 0); id_inst/id_pc = FIFO[rd_ptr].
  - Entries are registered, so latency from pc/ce sampled (issue cycle N) to id_valid is 2 cycles (valid in N+2).
  - When id_valid=0, id_inst/id_pc hold 0.
- Pop: id_valid & id_ready at edge advances rd_ptr.
- Pointer/count arithmetic:
  - rd_ptr/wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty is ignored; id_ready is don't-care while id_valid=0.
- Flush (priority over push/pop):
  - At the edge: count=0, pointers=0, inflight=0.
  - The in-flight ROM response is discarded.
  - In the flush cycle: rom_ce=0 and pc_stall=ce.
  - Next cycle: id_valid=0 and issue resumes from the current pc.
- Handshake stability: while id_valid=1 and id_ready=0, id_inst/id_pc remain stable until popped or flushed.
- No state machine beyond the issue/inflight/FIFO bookkeeping; total state is the FIFO array, pointers, count, inflight, inflight_pc.

Decomposition:
- Shared CPU defines package:
  - InstAddrBus width (AW=6), InstBus width (DW=32).
  - Constants ChipEnable/ChipDisable, RstEnable=1'b0.
  - Typedef for a {pc, inst} fetch entry.
- One natural sub-module: sync_fifo, a parameterised width/depth FIFO with count output and synchronous clear. if_fetch_buf instantiates it with width AW+DW and adds the issue/inflight logic.

Test Plan:
- Reset then steady stream:
  - Stimulus: rst low 2 cycles; ce=1; pc increments 0,1,2…; id_ready=1; ROM[i]=32'hA000_0000+i.
  - Response: first id_valid 2 cycles after pc=0 is issued, with id_pc=0, id_inst=32'hA000_0000; then one instruction per cycle, in order, with no stall.
- Back-pressure:
  - Stimulus: id_ready=0 from start.
  - Response: exactly 4 entries (pc 0..3) captured; pc_stall=1 with pc held at 4 and rom_ce=0; releasing id_ready drains 0..3 then 4, 5… with no gaps or duplicates.
- Simultaneous push/pop with a full FIFO:
  - Stimulus: toggle id_ready every cycle.
  - Response: count never exceeds 4; pointers wrap past 3→0 with id_pc continuous; no capture-into-full assertion fires.
- Flush with an in-flight read:
  - Stimulus: assert flush for 1 cycle when 2 entries are buffered and rom_ce was 1 in the prior cycle.
  - Response: next cycle id_valid=0; the discarded ROM word never appears; fetch resumes at the presented pc (e.g. pc=6'h20 → id_pc=6'h20).
- Reset mid-operation:
  - Stimulus: drive rst=0 for 1 cycle with FIFO full and id_ready=0.
  - Response: id_valid=0, id_inst=0, id_pc=0, pc_stall=0 after the edge; the following ROM data is ignored.
- ce low gaps:
  - Stimulus: ce pattern 1,0,0,1.
  - Response: rom_ce follows ce; only 2 entries delivered, with the correct pcs.
